nasti_wr_slave: RTL and testbench
=================================

// Module: nasti_wr_slave
// PURPOSE
//  NASTI write-channel slave front-end of the DDRx memory controller; sits directly downstream of a
//  nasti_if slave modport (AW/W/B) and upstream of the controller's write command queue.
//  Accepts one AW burst at a time, expands it into one per-beat write command (addr/data/strb), and returns one B response.
//  Reads are handled by a separate block.
// PARAMETERS
//  C_NASTI_ID_WIDTH    9   width of aw_id / b_id
//  C_NASTI_ADDR_WIDTH  16  byte address width
//  C_NASTI_DATA_WIDTH  64  data width (8..1024, power of 2); strobe width = /8
//  C_NASTI_USER_WIDTH  1   width of b_user
// PORTS
//  clk       in   1        clock; all logic on rising edge
//  rst       in   1        synchronous reset, active-high
//  aw_id     in   ID       write address id
//  aw_addr   in   ADDR     burst start byte address
//  aw_len    in   8        beats-1
//  aw_size   in   3        log2(bytes per beat)
//  aw_burst  in   2        0 FIXED, 1 INCR, 2 WRAP, 3 reserved
//  aw_valid  in   1        AW valid
//  aw_ready  out  1        AW ready
//  w_data    in   DATA     write data
//  w_strb    in   DATA/8   byte strobes
//  w_last    in   1        last beat marker
//  w_valid   in   1        W valid
//  w_ready   out  1        W ready
//  b_id      out  ID       response id (= accepted aw_id)
//  b_resp    out  2        2'b00 OKAY, 2'b10 SLVERR
//  b_user    out  USER     tied to 0
//  b_valid   out  1        B valid
//  b_ready   in   1        B ready
//  cmd_addr  out  ADDR     per-beat byte address to write queue
//  cmd_data  out  DATA     = w_data of current beat
//  cmd_strb  out  DATA/8   = w_strb of current beat
//  cmd_valid out  1        write command valid
//  cmd_ready in   1        write queue can accept
// BEHAVIOUR
//  Reset: state=IDLE; aw_ready=0 during rst, b_valid=0, cmd_valid=0, w_ready=0, b_resp=0, b_id=0, internal beat cnt/addr/err=0.
//  FSM IDLE -> DATA -> RESP -> IDLE; exactly one burst outstanding.
//  IDLE: aw_ready=1 (combinational from state). aw_valid&aw_ready latches id, addr, len, size, burst,
//   clears beat cnt and err, goes DATA. First W beat acceptable the next cycle.
//  AW-time error (burst=3, size>log2(DATA/8), or WRAP with len not in {1,3,7,15}): set err, mark burst DRAIN.
//  DATA (normal): cmd_valid=w_valid, w_ready=cmd_ready, cmd_addr=current beat addr register,
//   cmd_data/strb=w_data/w_strb (pass-through, zero latency). Beat completes on w_valid&w_ready.
//  DATA (DRAIN): w_ready=1, cmd_valid=0; beats counted and discarded.
//  Per beat: cnt+=1; addr update: FIXED unchanged; INCR addr+=(1<<size) modulo 2^ADDR (silent wrap);
//   WRAP: container=(len+1)<<size, addr=(addr&~(container-1)) | ((addr+(1<<size))&(container-1)).
//  Burst ends on the beat where cnt==len, regardless of w_last; next state RESP.
//  w_last mismatch (1 before final beat, or 0 on final beat): beat still written, err set.
//  W beats presented while IDLE or RESP are not accepted (w_ready=0).
//  RESP: b_valid=1 starting the cycle after the final beat; b_id=latched id, b_resp=err?2'b10:2'b00;
//   held stable until b_ready; on b_valid&b_ready -> IDLE (aw_ready=1 the following cycle).
//  Throughput: single-beat burst = AW, W, B in 3 consecutive cycles minimum.
//  Reset mid-burst: immediate return to IDLE; in-flight burst abandoned, no B issued, no further cmd.
//  Outputs valid-stable: cmd_valid follows w_valid; AXI rule that W source holds data keeps cmd stable.
// TESTING
//  INCR len=3 size=3 addr=0x0100, 4 W beats, cmd_ready=1 -> cmd_addr 0x100,0x108,0x110,0x118; B OKAY id echoed.
//  WRAP len=3 size=3 addr=0x0118 -> cmd_addr 0x118,0x100,0x108,0x110; B OKAY.
//  FIXED len=2 addr=0x0040, cmd_ready toggling 1/0 -> 3 cmds all 0x040, w_ready mirrors cmd_ready, no beat lost/duplicated.
//  burst=3 or size=4 (DATA=64), len=1 -> 2 beats drained, cmd_valid never 1, B SLVERR.
//  INCR len=1 with w_last=1 on beat 0 -> 2 cmds issued, B SLVERR; addr 0xFFF8 size=3 -> 0xFFF8,0x0000.
//  rst pulse after 2nd of 4 beats -> b_valid never asserts, aw_ready=1 after reset, next burst completes OKAY.

Source files
------------

// File: rtl/nasti_wr_slave.sv
// NASTI write-channel slave: accepts one AW burst, expands it into per-beat write
// commands for the controller's write queue, then returns a single B response.
module nasti_wr_slave #(
  parameter int C_NASTI_ID_WIDTH   = 9,
  parameter int C_NASTI_ADDR_WIDTH = 16,
  parameter int C_NASTI_DATA_WIDTH = 64,
  parameter int C_NASTI_USER_WIDTH = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [C_NASTI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [C_NASTI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                      aw_len_i,
  input  logic [2:0]                      aw_size_i,
  input  logic [1:0]                      aw_burst_i,
  input  logic                            aw_valid_i,
  output logic                            aw_ready_o,
  input  logic [C_NASTI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [C_NASTI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                            w_last_i,
  input  logic                            w_valid_i,
  output logic                            w_ready_o,
  output logic [C_NASTI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                      b_resp_o,
  output logic [C_NASTI_USER_WIDTH-1:0]   b_user_o,
  output logic                            b_valid_o,
  input  logic                            b_ready_i,
  output logic [C_NASTI_ADDR_WIDTH-1:0]   cmd_addr_o,
  output logic [C_NASTI_DATA_WIDTH-1:0]   cmd_data_o,
  output logic [C_NASTI_DATA_WIDTH/8-1:0] cmd_strb_o,
  output logic                            cmd_valid_o,
  input  logic                            cmd_ready_i
);
  localparam int AW = C_NASTI_ADDR_WIDTH;
  localparam int LG_BYTES = $clog2(C_NASTI_DATA_WIDTH/8);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] B_FIXED = 2'd0;
  localparam logic [1:0] B_INCR  = 2'd1;
  localparam logic [1:0] B_WRAP  = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [C_NASTI_ID_WIDTH-1:0] id_q, id_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [7:0]                  len_q, len_d;
  logic [2:0]                  size_q, size_d;
  logic [1:0]                  burst_q, burst_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        drain_q, drain_d;

  logic          aw_hs, w_hs, last_beat, aw_err, wrap_len_ok;
  logic [AW-1:0] step, addr_inc, cont_mask, addr_next;

  assign aw_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign w_ready_o   = (state_q == S_DATA) && (drain_q || cmd_ready_i);
  assign cmd_valid_o = (state_q == S_DATA) && !drain_q && w_valid_i;
  assign cmd_addr_o  = addr_q;
  assign cmd_data_o  = w_data_i;
  assign cmd_strb_o  = w_strb_i;
  assign b_valid_o   = (state_q == S_RESP);
  assign b_id_o      = id_q;
  assign b_resp_o    = err_q ? 2'b10 : 2'b00;
  assign b_user_o    = '0;

  assign aw_hs     = aw_valid_i && aw_ready_o;
  assign w_hs      = w_valid_i && w_ready_o;
  assign last_beat = (cnt_q == len_q);

  assign wrap_len_ok = (aw_len_i == 8'd1) || (aw_len_i == 8'd3) ||
                       (aw_len_i == 8'd7) || (aw_len_i == 8'd15);
  assign aw_err = (aw_burst_i == 2'd3) || (aw_size_i > 3'(LG_BYTES)) ||
                  ((aw_burst_i == B_WRAP) && !wrap_len_ok);

  // WRAP keeps the upper bits of the container-aligned base and wraps the offset.
  assign step      = AW'(1) << size_q;
  assign addr_inc  = addr_q + step;
  assign cont_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);

  always_comb begin
    addr_next = addr_q;
    case (burst_q)
      B_INCR:  addr_next = addr_inc;
      B_WRAP:  addr_next = (addr_q & ~cont_mask) | (addr_inc & cont_mask);
      default: addr_next = addr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: if (aw_hs) begin
        id_d    = aw_id_i;
        addr_d  = aw_addr_i;
        len_d   = aw_len_i;
        size_d  = aw_size_i;
        burst_d = aw_burst_i;
        cnt_d   = 8'd0;
        err_d   = aw_err;
        drain_d = aw_err;
        state_d = S_DATA;
      end
      S_DATA: if (w_hs) begin
        cnt_d  = cnt_q + 8'd1;
        addr_d = addr_next;
        if (w_last_i != last_beat) err_d = 1'b1;
        if (last_beat) state_d = S_RESP;
      end
      S_RESP: if (b_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      drain_q <= drain_d;
    end
  end
endmodule

// File: tb/tb_nasti_wr_slave.sv
// Randomized bench for nasti_wr_slave; expected addresses/responses come from an
// arithmetic model of the burst rules, checked every cycle on the falling edge.
module tb_nasti_wr_slave;
  localparam int IDW = 9, AW = 16, DW = 64, UW = 1;

  logic          clk = 0, rst = 1;
  logic [IDW-1:0] aw_id = 0;
  logic [AW-1:0]  aw_addr = 0;
  logic [7:0]     aw_len = 0;
  logic [2:0]     aw_size = 0;
  logic [1:0]     aw_burst = 0;
  logic           aw_valid = 0, aw_ready;
  logic [DW-1:0]  w_data = 0;
  logic [DW/8-1:0] w_strb = 0;
  logic           w_last = 0, w_valid = 0, w_ready;
  logic [IDW-1:0] b_id;
  logic [1:0]     b_resp;
  logic [UW-1:0]  b_user;
  logic           b_valid, b_ready = 0;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_data;
  logic [DW/8-1:0] cmd_strb;
  logic           cmd_valid, cmd_ready = 0;

  int errors = 0, checks = 0;

  nasti_wr_slave #(.C_NASTI_ID_WIDTH(IDW), .C_NASTI_ADDR_WIDTH(AW),
                   .C_NASTI_DATA_WIDTH(DW), .C_NASTI_USER_WIDTH(UW)) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
    .aw_burst_i(aw_burst), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid),
    .w_ready_o(w_ready),
    .b_id_o(b_id), .b_resp_o(b_resp), .b_user_o(b_user), .b_valid_o(b_valid),
    .b_ready_i(b_ready),
    .cmd_addr_o(cmd_addr), .cmd_data_o(cmd_data), .cmd_strb_o(cmd_strb),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready)
  );

  always #5 clk = ~clk;

  // Beat address from first principles: offset within the wrap container, or linear step.
  function automatic logic [AW-1:0] exp_addr(int a0, int len, int size, int burst, int i);
    longint bytes, cont, base, r;
    bytes = longint'(1) << size;
    case (burst)
      1: r = (a0 + i * bytes) % 65536;
      2: begin
        cont = (len + 1) * bytes;
        base = a0 - (a0 % cont);
        r = base + ((a0 % cont) + i * bytes) % cont;
      end
      default: r = a0;
    endcase
    return AW'(r);
  endfunction

  function automatic bit exp_aw_err(int len, int size, int burst);
    return (burst == 3) || (size > 3) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // rdy_mode: 0 cmd_ready always 1, 1 toggle 1/0, 2 random with random W gaps
  task automatic run_burst(input int id, input int a0, input int len, input int size,
                           input int burst, input int flip, input int rdy_mode,
                           input int stop_after);
    bit drain, err, tog;
    int i, cyc;
    logic [DW-1:0] d;
    logic [DW/8-1:0] s;
    drain = exp_aw_err(len, size, burst);
    err = drain;
    tog = 1;
    @(negedge clk);
    aw_id = IDW'(id); aw_addr = AW'(a0); aw_len = 8'(len);
    aw_size = 3'(size); aw_burst = 2'(burst); aw_valid = 1;
    #1;
    checks++;
    if (aw_ready !== 1'b1) begin
      errors++; $display("FAIL aw_ready_idle got=%b exp=1", aw_ready);
    end
    @(negedge clk);
    aw_valid = 0;
    i = 0; cyc = 0;
    while (i <= len) begin
      if (stop_after >= 0 && i == stop_after) begin
        w_valid = 0;
        return;
      end
      if (cyc > 400) begin
        errors++; checks++;
        $display("FAIL beat_timeout beat=%0d of len=%0d", i, len);
        w_valid = 0;
        return;
      end
      d = {$urandom, $urandom};
      s = DW/8'($urandom);
      w_data = d; w_strb = s;
      w_last = (i == len) ^ (i == flip);
      w_valid = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (rdy_mode)
        0: cmd_ready = 1;
        1: begin cmd_ready = tog; tog = ~tog; end
        default: cmd_ready = $urandom_range(0, 1);
      endcase
      #1;
      checks++;
      if (drain) begin
        if (w_ready !== 1'b1 || cmd_valid !== 1'b0) begin
          errors++;
          $display("FAIL drain_beat beat=%0d w_ready=%b cmd_valid=%b exp=1/0", i, w_ready, cmd_valid);
        end
      end else begin
        if (w_ready !== cmd_ready || cmd_valid !== w_valid) begin
          errors++;
          $display("FAIL hs_beat beat=%0d w_ready=%b cmd_valid=%b exp=%b/%b",
                   i, w_ready, cmd_valid, cmd_ready, w_valid);
        end
        if (w_valid) begin
          checks++;
          if (cmd_addr !== exp_addr(a0, len, size, burst, i) || cmd_data !== d || cmd_strb !== s) begin
            errors++;
            $display("FAIL cmd_beat beat=%0d addr=%h data=%h strb=%h exp addr=%h data=%h strb=%h",
                     i, cmd_addr, cmd_data, cmd_strb, exp_addr(a0, len, size, burst, i), d, s);
          end
        end
      end
      if (w_valid && (drain || cmd_ready)) begin
        if (w_last != (i == len)) err = 1;
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    w_valid = 0; w_last = 0; cmd_ready = 0;
    b_ready = 0;
    #1;
    for (int k = $urandom_range(0, 2); k >= 0; k--) begin
      b_ready = (k == 0);
      #1;
      checks++;
      if (b_valid !== 1'b1 || b_id !== IDW'(id) || b_resp !== (err ? 2'b10 : 2'b00) ||
          b_user !== '0 || w_ready !== 1'b0 || aw_ready !== 1'b0) begin
        errors++;
        $display("FAIL b_resp valid=%b id=%h resp=%b wr=%b awr=%b exp 1/%h/%b/0/0",
                 b_valid, b_id, b_resp, w_ready, aw_ready, IDW'(id), err ? 2'b10 : 2'b00);
      end
      @(negedge clk);
    end
    b_ready = 0;
    #1;
    checks++;
    if (aw_ready !== 1'b1 || b_valid !== 1'b0) begin
      errors++; $display("FAIL back_to_idle aw_ready=%b b_valid=%b exp=1/0", aw_ready, b_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    w_valid = 1; cmd_ready = 1; aw_valid = 1;
    #1;
    checks++;
    if (aw_ready !== 0 || b_valid !== 0 || cmd_valid !== 0 || w_ready !== 0 ||
        b_resp !== 0 || b_id !== 0) begin
      errors++;
      $display("FAIL reset_state awr=%b bv=%b cv=%b wr=%b resp=%b id=%h exp all 0",
               aw_ready, b_valid, cmd_valid, w_ready, b_resp, b_id);
    end
    aw_valid = 0;
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (aw_ready !== 1 || w_ready !== 0 || cmd_valid !== 0) begin
      errors++;
      $display("FAIL idle_ignores_w awr=%b wr=%b cv=%b exp=1/0/0", aw_ready, w_ready, cmd_valid);
    end
    w_valid = 0; cmd_ready = 0;
  endtask

  task automatic test_incr();      run_burst(9'h1A5, 16'h0100, 3, 3, 1, -1, 0, -1); endtask
  task automatic test_wrap();      run_burst(9'h033, 16'h0118, 3, 3, 2, -1, 0, -1); endtask
  task automatic test_fixed_bp();  run_burst(9'h0F0, 16'h0040, 2, 3, 0, -1, 1, -1); endtask
  task automatic test_single();    run_burst(9'h100, 16'h1234, 0, 2, 1, -1, 0, -1); endtask

  task automatic test_drain();
    run_burst(9'h011, 16'h0200, 1, 3, 3, -1, 0, -1);
    run_burst(9'h012, 16'h0200, 1, 4, 1, -1, 2, -1);
    run_burst(9'h013, 16'h0200, 2, 3, 2, -1, 0, -1);
  endtask

  task automatic test_wlast();
    run_burst(9'h055, 16'h0300, 1, 3, 1, 0, 0, -1);
    run_burst(9'h056, 16'h0300, 2, 3, 1, 2, 0, -1);
  endtask

  task automatic test_addr_wrap(); run_burst(9'h077, 16'hFFF8, 1, 3, 1, -1, 0, -1); endtask

  task automatic test_reset_mid();
    run_burst(9'h0AA, 16'h0500, 3, 3, 1, -1, 0, 2);
    rst = 1;
    #1;
    checks++;
    if (aw_ready !== 0) begin errors++; $display("FAIL rst_mid_awr got=%b exp=0", aw_ready); end
    @(negedge clk);
    rst = 0;
    w_valid = 1; cmd_ready = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (aw_ready !== 1 || b_valid !== 0 || cmd_valid !== 0 || w_ready !== 0) begin
        errors++;
        $display("FAIL rst_mid_idle awr=%b bv=%b cv=%b wr=%b exp=1/0/0/0",
                 aw_ready, b_valid, cmd_valid, w_ready);
      end
      @(negedge clk);
    end
    w_valid = 0; cmd_ready = 0;
    run_burst(9'h0AB, 16'h0600, 3, 3, 1, -1, 0, -1);
  endtask

  task automatic test_random();
    int len, size, burst, flip, a0;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: len = 0; 1: len = 1; 2: len = 3; 3: len = 7; 4: len = 15;
        default: len = $urandom_range(0, 9);
      endcase
      burst = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      size = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      flip = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      a0 = $urandom_range(0, 65535);
      run_burst($urandom_range(0, 511), a0, len, size, burst, flip, 2, -1);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_bp();
    test_single();
    test_drain();
    test_wlast();
    test_addr_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
